// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder for a cache miss path.
// It accepts one request at a time, waits LATENCY cycles and then returns a one-cycle response.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_wr_en_i, req_addr_i, req_wr_data_i, req_byte_en_i  request payload, latched on accept
//   resp_valid_o, resp_data_o, resp_err_o                   one-cycle response
//   txn_count_o                                              completed-transaction counter
module main_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wr_data_i,
  input  logic [3:0]            req_byte_en_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic [15:0]           txn_count_o
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [DATA_WIDTH-1:0] NoData = DATA_WIDTH'(32'hDEADBEEF);
  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_en_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [3:0]            be_q;
  logic [15:0]           txn_cnt_q;

  // Store contents survive rst; they only start out as zero.
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS] = '{default: '0};

  function automatic logic be_ok(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0011) || (be == 4'b1111);
  endfunction

  logic                  accept;
  logic                  enter_resp;
  logic                  op_wr;
  logic [IdxW-1:0]       op_idx;
  logic [DATA_WIDTH-1:0] op_data;
  logic [3:0]            op_be;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept = (state_q == StIdle) && req_valid_i;

  // With LATENCY == 1 the write commits on the accept edge itself, before the payload registers
  // hold the request, so the commit path takes the live inputs while idle.
  always_comb begin
    if (state_q == StIdle) begin
      op_wr   = req_wr_en_i;
      op_idx  = req_addr_i[IdxW+1:2];
      op_data = req_wr_data_i;
      op_be   = req_byte_en_i;
    end else begin
      op_wr   = wr_en_q;
      op_idx  = idx_q;
      op_data = wr_data_q;
      op_be   = be_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StAccess;
            cnt_d   = LatM1;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  always_comb begin
    old_word = mem_q[op_idx];
    new_word = old_word;
    if (op_be == 4'b1111) begin
      new_word = op_data;
    end else if (op_be == 4'b0011) begin
      new_word[15:0] = op_data[15:0];
    end else begin
      new_word[7:0] = op_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wr_en_q   <= 1'b0;
      idx_q     <= '0;
      wr_data_q <= '0;
      be_q      <= 4'd0;
      txn_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_en_q   <= req_wr_en_i;
        idx_q     <= req_addr_i[IdxW+1:2];
        wr_data_q <= req_wr_data_i;
        be_q      <= req_byte_en_i;
      end
      if (state_q == StResp) txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_wr && be_ok(op_be)) begin
      mem_q[op_idx] <= new_word;
    end
  end

  assign rd_word = mem_q[idx_q];

  always_comb begin
    resp_data_o = NoData;
    if ((state_q == StResp) && !wr_en_q) begin
      if (be_q == 4'b1111) begin
        resp_data_o = rd_word;
      end else if (be_q == 4'b0011) begin
        resp_data_o = {{(DATA_WIDTH-16){1'b0}}, rd_word[15:0]};
      end else if (be_q == 4'b0001) begin
        resp_data_o = {{(DATA_WIDTH-8){1'b0}}, rd_word[7:0]};
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_err_o   = (state_q == StResp) && !be_ok(be_q);
  assign txn_count_o  = txn_cnt_q;

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

  localparam int Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_en_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wr_data_i;
  logic [3:0]  req_byte_en_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [15:0] txn_count_o;

  main_mem_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_WORDS (1024),
    .LATENCY   (Lat)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wr_en_i  (req_wr_en_i),
    .req_addr_i   (req_addr_i),
    .req_wr_data_i(req_wr_data_i),
    .req_byte_en_i(req_byte_en_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .txn_count_o  (txn_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pops the oldest expected response and compares it with the current DUT response.
  task automatic check_resp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, " unexpected response"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " data"}, resp_data_o, e.data);
      check({tag, " err"}, {31'd0, resp_err_o}, {31'd0, e.err});
      exp_cnt++;
    end
  endtask

  // Issue one request at a negedge, then follow it to completion at negedges.
  task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_data, input logic exp_err);
    int   k;
    exp_t e;
    k = 0;
    while (!req_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready before issue"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i   = 1'b1;
    req_wr_en_i   = wr;
    req_addr_i    = a;
    req_wr_data_i = d;
    req_byte_en_i = be;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble the payload: it must be ignored while busy.
    req_valid_i   = 1'b0;
    req_wr_en_i   = ~wr;
    req_addr_i    = $urandom;
    req_wr_data_i = $urandom;
    req_byte_en_i = 4'b1111;
    k = 1;
    while (!resp_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(Lat));
    if (resp_valid_o) check_resp(tag);
    else void'(sb_q.pop_front());
    @(negedge clk);
    check({tag, " txn_count"}, {16'd0, txn_count_o}, 32'(exp_cnt));
    check({tag, " ready after resp"}, {31'd0, req_ready_o}, 32'd1);
    check({tag, " data idle"}, resp_data_o, 32'hDEADBEEF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid_i = 1'b0;
    exp_cnt = 0;
    sb_q.delete();
  endtask

  int last;
  int seen;

  initial begin
    rst = 1'b0;
    req_valid_i = 1'b0;
    req_wr_en_i = 1'b0;
    req_addr_i = '0;
    req_wr_data_i = '0;
    req_byte_en_i = 4'b1111;
    @(negedge clk);
    do_reset();

    check("reset ready", {31'd0, req_ready_o}, 32'd1);
    check("reset valid", {31'd0, resp_valid_o}, 32'd0);
    check("reset err", {31'd0, resp_err_o}, 32'd0);
    check("reset data", resp_data_o, 32'hDEADBEEF);
    check("reset count", {16'd0, txn_count_o}, 32'd0);

    // Word write then read back
    txn("wr40", 1'b1, 32'h40, 32'h12345678, 4'b1111, 32'hDEADBEEF, 1'b0);
    txn("rd40", 1'b0, 32'h40, 32'h0, 4'b1111, 32'h12345678, 1'b0);
    check("count after two", {16'd0, txn_count_o}, 32'd2);

    // Byte write with junk upper bits, then word/half/byte reads
    txn("wrb40", 1'b1, 32'h40, 32'hFFFFFFAB, 4'b0001, 32'hDEADBEEF, 1'b0);
    txn("rdw40", 1'b0, 32'h40, 32'h0, 4'b1111, 32'h123456AB, 1'b0);
    txn("rdh40", 1'b0, 32'h40, 32'h0, 4'b0011, 32'h000056AB, 1'b0);
    txn("rdb40", 1'b0, 32'h40, 32'h0, 4'b0001, 32'h000000AB, 1'b0);

    // Half write to another word
    txn("wrw44", 1'b1, 32'h44, 32'hA5A5A5A5, 4'b1111, 32'hDEADBEEF, 1'b0);
    txn("wrh44", 1'b1, 32'h46, 32'h9999BEEF, 4'b0011, 32'hDEADBEEF, 1'b0);
    txn("rdw44", 1'b0, 32'h44, 32'h0, 4'b1111, 32'hA5A5BEEF, 1'b0);

    // Unsupported byte enables: error, no write
    txn("rderr", 1'b0, 32'h40, 32'h0, 4'b0101, 32'hDEADBEEF, 1'b1);
    txn("wrerr", 1'b1, 32'h40, 32'h0BADF00D, 4'b0111, 32'hDEADBEEF, 1'b1);
    txn("rd40 unchanged", 1'b0, 32'h40, 32'h0, 4'b1111, 32'h123456AB, 1'b0);

    // Address aliasing: 0x1040 maps to word 0x40
    txn("alias rd", 1'b0, 32'h1040, 32'h0, 4'b1111, 32'h123456AB, 1'b0);
    txn("alias wr", 1'b1, 32'hFFFF_0048, 32'h0F0F0F0F, 4'b1111, 32'hDEADBEEF, 1'b0);
    txn("alias rd48", 1'b0, 32'h48, 32'h0, 4'b1111, 32'h0F0F0F0F, 1'b0);

    // Back-to-back: valid held high, accepts exactly Lat+1 cycles apart
    req_valid_i = 1'b1;
    req_wr_en_i = 1'b0;
    req_addr_i = 32'h40;
    req_byte_en_i = 4'b1111;
    last = -1;
    for (int i = 0; i < 16; i++) begin
      if (resp_valid_o) check_resp("b2b resp");
      if (req_ready_o) begin
        if (last >= 0) check("b2b spacing", 32'(i - last), 32'(Lat + 1));
        sb_q.push_back('{data: 32'h123456AB, err: 1'b0});
        last = i;
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    check("b2b last accept", 32'(last), 32'd15);
    seen = 0;
    while (sb_q.size() > 0 && seen < 20) begin
      if (resp_valid_o) check_resp("b2b drain");
      @(negedge clk);
      seen++;
    end
    check("b2b drained", 32'(sb_q.size()), 32'd0);
    check("b2b count", {16'd0, txn_count_o}, 32'(exp_cnt));

    // Reset in ACCESS drops a write
    txn("pre80", 1'b1, 32'h80, 32'h11112222, 4'b1111, 32'hDEADBEEF, 1'b0);
    req_valid_i = 1'b1;
    req_wr_en_i = 1'b1;
    req_addr_i = 32'h80;
    req_wr_data_i = 32'hCAFEF00D;
    req_byte_en_i = 4'b1111;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("rst ready", {31'd0, req_ready_o}, 32'd1);
    check("rst count", {16'd0, txn_count_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid_o) seen++;
      @(negedge clk);
    end
    check("rst no resp", 32'(seen), 32'd0);
    txn("rd80 old", 1'b0, 32'h80, 32'h0, 4'b1111, 32'h11112222, 1'b0);
    check("rst count read only", {16'd0, txn_count_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
